// File: rtl/mem_resp_pkg.sv
// Shared types and sizes for the 2-bit-address / 8-bit-data memory bus.
// Imported by the responder RTL and by the memory agent's driver and monitor.
package mem_resp_pkg;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_e;
endpackage

// File: rtl/mem_resp_sat_cnt.sv
// Saturating up-counter: steps by one on inc and sticks at all-ones.
module mem_resp_sat_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: 4x8 register file, registered read response with
// uninitialised-entry flag. Optional access counters under MEM_ACC_CNT_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                CNT_W    = 10,
  parameter logic [DATA_W-1:0] RST_DATA = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rw,
  input  logic              mem_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_uninit,
`ifdef MEM_ACC_CNT_EN
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
`endif
  output resp_state_e       resp_state
);
  // Handshake: no backpressure; every posedge with mem_en=1 consumes one
  // command, and rd_valid is a pure qualifier on rd_data/rd_uninit.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  resp_state_e       state_q;
  resp_state_e       state_d;
  logic              wr_cmd;
  logic              rd_cmd;

  assign wr_cmd = mem_en && (mem_op_e'(mem_rw) == MEM_WR);
  assign rd_cmd = mem_en && (mem_op_e'(mem_rw) == MEM_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_DATA;
      end
      written   <= '0;
      rd_data   <= RST_DATA;
      rd_uninit <= 1'b0;
    end else if (wr_cmd) begin
      mem[mem_addr]     <= mem_data;
      written[mem_addr] <= 1'b1;
    end else if (rd_cmd) begin
      rd_data   <= mem[mem_addr];
      rd_uninit <= ~written[mem_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any cycle that is not a read drops the response.
  always_comb begin
    state_d = ST_IDLE;
    if (rd_cmd) begin
      state_d = ST_RESP;
    end
  end

  assign rd_valid   = (state_q == ST_RESP);
  assign resp_state = state_q;

`ifdef MEM_ACC_CNT_EN
  mem_resp_sat_cnt #(.W(CNT_W)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wr_cmd),
    .cnt (wr_cnt)
  );

  mem_resp_sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_cmd),
    .cnt (rd_cnt)
  );
`endif
endmodule
